alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (A, B, ALUFun[5:0], Sign -> S[31:0]) between two requesters.
//  Typical pairing: port 0 = execute stage, port 1 = branch-compare / multi-cycle unit.
//  Round-robin grant, operands registered into the ALU, result registered and returned
//  on the granted port's response channel with valid/ready handshakes.
// PARAMETERS
//  WIDTH      32  operand/result width
//  FUN_W      6   ALUFun width (ALUFun codes: 000001 SUB, 110011 EQ, 110001 NEQ, 110101 LT,
//                 111101 LEZ, 111011 LTZ, 111111 GTZ; others passed through unchanged)
//  PRIO_INIT  0   port holding priority after reset (0 or 1)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high
//  reqN_valid   in   1      N=0,1: request present
//  reqN_ready   out  1      request accepted this cycle when valid&ready
//  reqN_a       in   WIDTH  operand A
//  reqN_b       in   WIDTH  operand B
//  reqN_fun     in   FUN_W  ALUFun
//  reqN_sign    in   1      Sign (1 = signed compare/overflow)
//  respN_valid  out  1      result available for port N
//  respN_ready  in   1      port N consumes result when valid&ready
//  respN_data   out  WIDTH  registered ALU S
//  alu_A        out  WIDTH  to shared ALU
//  alu_B        out  WIDTH  to shared ALU
//  alu_ALUFun   out  FUN_W  to shared ALU
//  alu_Sign     out  1      to shared ALU
//  alu_S        in   WIDTH  from shared ALU (combinational)
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, all reqN_ready/respN_valid=0, respN_data=0, alu_* regs=0,
//   owner=0, priority pointer=PRIO_INIT. Reset mid-operation discards the in-flight op.
//  FSM IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE: grant = priority port if its valid, else other port if valid. reqN_ready is
//   combinational = (state==IDLE) & grant==N; at most one ready high. On grant: latch
//   a/b/fun/sign into alu_* regs, owner<=N, pointer<=~N (loser of a tie gets priority
//   next), go ISSUE. No valid: stay IDLE, pointer unchanged.
//  ISSUE (1 cycle): alu_* stable; respOwner_data <= alu_S at cycle end; go RESP.
//  RESP: respOwner_valid=1, data held stable until respOwner_ready; on handshake
//   go IDLE (new grant possible next cycle, not same cycle). Other port's resp_valid=0.
//  Latency: accept at cycle t -> respN_valid at t+2; max one op per 3 cycles.
//  alu_* outputs always driven from the registers (hold last op between ops).
//  Requests not granted must hold valid/operands; arbiter never drops a held request.
//  Starvation: with both ports continuously valid, grants strictly alternate.
//  Response backpressure: RESP held indefinitely; reqN_ready stays 0 meanwhile.
//  No width extension: alu_S copied verbatim (compare ops yield 0/1 in bit 0).
// TESTING (bench wires the team ALU behind alu_*)
//  1 Reset: assert reset mid-RESP -> resp valids 0 immediately, busy=0, next grant to PRIO_INIT port.
//  2 Single op: req0 A=8,B=3,fun=000001,sign=1 -> resp0_valid at t+2, data=5; resp1_valid stays 0.
//  3 Compare: req1 A=8,B=8,fun=110011 -> resp1_data=1; A=8,B=32'hB38F0F83,fun=110101,sign=1 -> 0.
//  4 Tie: both valid every cycle, PRIO_INIT=0 -> grant order 0,1,0,1; ready never both high.
//  5 Backpressure: resp0_ready=0 for 5 cycles -> resp0_valid/data stable, req1 not accepted until handshake.
//  6 Zero compare: req0 A=0,B=0,fun=111101 -> 1; fun=111011 -> 0; fun=111111 -> 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Operands are registered into the ALU, and the result is registered and returned on the owner's response channel.
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter int FUN_W     = 6,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FUN_W-1:0] req0_fun,
  input  logic             req0_sign,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FUN_W-1:0] req1_fun,
  input  logic             req1_sign,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [FUN_W-1:0] alu_ALUFun,
  output logic             alu_Sign,
  input  logic [WIDTH-1:0] alu_S,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               prio_q, prio_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic               grant_vld, grant_idx, resp_hs;

  // Grants are held off while reset is asserted.
  // A request accepted then could not be latched and would be silently lost.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = prio_q;
    if (state_q == IDLE && !reset) begin
      if (prio_q ? req1_valid : req0_valid) begin
        grant_vld = 1'b1;
        grant_idx = prio_q;
      end else if (prio_q ? req0_valid : req1_valid) begin
        grant_vld = 1'b1;
        grant_idx = ~prio_q;
      end
    end
  end

  assign resp_hs = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    sign_d  = sign_q;
    data0_d = data0_q;
    data1_d = data1_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d     = grant_idx ? req1_a    : req0_a;
          b_d     = grant_idx ? req1_b    : req0_b;
          fun_d   = grant_idx ? req1_fun  : req0_fun;
          sign_d  = grant_idx ? req1_sign : req0_sign;
          owner_d = grant_idx;
          prio_d  = ~grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_q) data1_d = alu_S;
        else         data0_d = alu_S;
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= PRIO_INIT;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      sign_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      sign_q  <= sign_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign req0_ready  = grant_vld & ~grant_idx;
  assign req1_ready  = grant_vld &  grant_idx;
  assign resp0_valid = (state_q == RESP) & ~owner_q;
  assign resp1_valid = (state_q == RESP) &  owner_q;
  assign resp0_data  = data0_q;
  assign resp1_data  = data1_q;
  assign alu_A       = a_q;
  assign alu_B       = b_q;
  assign alu_ALUFun  = fun_q;
  assign alu_Sign    = sign_q;
  assign busy        = (state_q != IDLE);

endmodule
